// File: rtl/xip_arb_pkg.sv
// Shared types for the XIP flash bus arbiter: FSM state encoding and master indices.
package xip_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } arb_state_e;

    localparam logic MST_IBUS = 1'b0;
    localparam logic MST_DBUS = 1'b1;

endpackage

// File: rtl/xip_rr_arb2.sv
// Combinational two-way round-robin pick: a lone requester wins, a tie goes to prio.
module xip_rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic       winner,
    output logic       any_req
);

    assign any_req = |req;
    assign winner  = (&req) ? prio : req[1];

endmodule

// File: rtl/xip_bus_arbiter.sv
// Shares the single-outstanding XIP flash OBI port between ibus (master 0) and dbus (master 1),
// holding the selection until grant and steering the response back to the owner.
module xip_bus_arbiter
    import xip_arb_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_data_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_data_o,
    output logic        s_req_o,
    output logic        s_we_o,
    output logic [3:0]  s_be_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    input  logic        s_gnt_i,
    input  logic        s_rvalid_i,
    input  logic [31:0] s_data_i
);

    // Handshake: a master's request is accepted in the cycle its gnt is high; its response is
    // the single cycle its rvalid is high. Only one transaction is ever outstanding downstream.

    arb_state_e state_q, state_d;
    logic       sel_q, sel_d;
    logic       owner_q, owner_d;
    logic       prio_q, prio_d;

    logic [1:0] req_vec;
    logic       rr_winner;
    logic       rr_any;
    logic       fwd_valid;
    logic       fwd_idx;
    logic [1:0] gnt;
    logic [1:0] rvalid;

    assign req_vec = {m1_req_i, m0_req_i};

    xip_rr_arb2 u_rr_arb2 (
        .req     (req_vec),
        .prio    (prio_q),
        .winner  (rr_winner),
        .any_req (rr_any)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            sel_q   <= MST_IBUS;
            owner_q <= MST_IBUS;
            prio_q  <= MST_IBUS;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        owner_d   = owner_q;
        prio_d    = prio_q;
        fwd_valid = 1'b0;
        fwd_idx   = sel_q;
        gnt       = 2'b00;
        rvalid    = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (rr_any) begin
                    fwd_valid = 1'b1;
                    fwd_idx   = rr_winner;
                    if (s_gnt_i) begin
                        gnt[rr_winner] = 1'b1;
                        owner_d        = rr_winner;
                        prio_d         = ~rr_winner;
                        state_d        = S_WAIT;
                    end else begin
                        sel_d   = rr_winner;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // Selection is frozen here; a withdrawn request abandons the attempt.
                if (req_vec[sel_q]) begin
                    fwd_valid = 1'b1;
                    if (s_gnt_i) begin
                        gnt[sel_q] = 1'b1;
                        owner_d    = sel_q;
                        prio_d     = ~sel_q;
                        state_d    = S_WAIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (s_rvalid_i) begin
                    rvalid[owner_q] = 1'b1;
                    state_d         = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!rst_ni) begin
            fwd_valid = 1'b0;
            gnt       = 2'b00;
            rvalid    = 2'b00;
        end
    end

    assign s_req_o  = fwd_valid;
    assign s_we_o   = fwd_valid & (fwd_idx ? m1_we_i : m0_we_i);
    assign s_be_o   = fwd_valid ? (fwd_idx ? m1_be_i : m0_be_i) : 4'h0;
    assign s_addr_o = fwd_valid ? (fwd_idx ? m1_addr_i : m0_addr_i) : 32'h0;
    assign s_data_o = fwd_valid ? (fwd_idx ? m1_data_i : m0_data_i) : 32'h0;

    assign m0_gnt_o    = gnt[MST_IBUS];
    assign m1_gnt_o    = gnt[MST_DBUS];
    assign m0_rvalid_o = rvalid[MST_IBUS];
    assign m1_rvalid_o = rvalid[MST_DBUS];
    assign m0_data_o   = rst_ni ? s_data_i : 32'h0;
    assign m1_data_o   = rst_ni ? s_data_i : 32'h0;

endmodule

// File: tb/tb_xip_bus_arbiter.sv
// Bench for xip_bus_arbiter: directed scenarios plus random traffic against a cycle reference model.
module tb_xip_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [3:0]  m0_be, m1_be;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_we, s_gnt, s_rvalid;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata, s_rdata;

    always #5 clk = ~clk;

    xip_bus_arbiter dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .m0_req_i    (m0_req),
        .m0_we_i     (m0_we),
        .m0_be_i     (m0_be),
        .m0_addr_i   (m0_addr),
        .m0_data_i   (m0_wdata),
        .m0_gnt_o    (m0_gnt),
        .m0_rvalid_o (m0_rvalid),
        .m0_data_o   (m0_rdata),
        .m1_req_i    (m1_req),
        .m1_we_i     (m1_we),
        .m1_be_i     (m1_be),
        .m1_addr_i   (m1_addr),
        .m1_data_i   (m1_wdata),
        .m1_gnt_o    (m1_gnt),
        .m1_rvalid_o (m1_rvalid),
        .m1_data_o   (m1_rdata),
        .s_req_o     (s_req),
        .s_we_o      (s_we),
        .s_be_o      (s_be),
        .s_addr_o    (s_addr),
        .s_data_o    (s_wdata),
        .s_gnt_i     (s_gnt),
        .s_rvalid_i  (s_rvalid),
        .s_data_i    (s_rdata)
    );

    int checks = 0;
    int errors = 0;

    logic [137:0] obs_vec, exp_vec;
    assign obs_vec = {m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, s_req, s_we, s_be,
                      s_addr, s_wdata, m0_rdata, m1_rdata};

    // Reference model: busy = a transaction is outstanding, held = master whose request is
    // being presented but not yet granted (-1 none), rr = master preferred on a tie.
    int m_busy = 0, m_owner = 0, m_held = -1, m_rr = 0;
    int n_busy, n_owner, n_held, n_rr;

    logic [31:0] exp_q[$];

    task automatic model_eval();
        logic [1:0]  rq, g, rv;
        int          w, fwd;
        logic        we_f;
        logic [3:0]  be_f;
        logic [31:0] a_f, d_f, rd;
        rq = {m1_req, m0_req};
        g = 2'b00; rv = 2'b00; w = -1; fwd = -1;
        n_busy = m_busy; n_owner = m_owner; n_held = m_held; n_rr = m_rr;
        if (!rst_n) begin
            n_busy = 0; n_owner = 0; n_held = -1; n_rr = 0;
        end else if (m_busy != 0) begin
            if (s_rvalid) begin
                rv[m_owner] = 1'b1;
                n_busy = 0;
            end
        end else begin
            if (m_held >= 0) w = rq[m_held] ? m_held : -1;
            else if (rq == 2'b11) w = m_rr;
            else if (rq != 2'b00) w = rq[1] ? 1 : 0;
            n_held = -1;
            if (w >= 0) begin
                fwd = w;
                if (s_gnt) begin
                    g[w] = 1'b1; n_busy = 1; n_owner = w; n_rr = 1 - w;
                end else begin
                    n_held = w;
                end
            end
        end
        we_f = 1'b0; be_f = 4'h0; a_f = 32'h0; d_f = 32'h0;
        if (fwd == 0) begin we_f = m0_we; be_f = m0_be; a_f = m0_addr; d_f = m0_wdata; end
        if (fwd == 1) begin we_f = m1_we; be_f = m1_be; a_f = m1_addr; d_f = m1_wdata; end
        rd = rst_n ? s_rdata : 32'h0;
        exp_vec = {g[0], rv[0], g[1], rv[1], (fwd >= 0), we_f, be_f, a_f, d_f, rd, rd};
    endtask

    task automatic adv();
        @(posedge clk);
        m_busy = n_busy; m_owner = n_owner; m_held = n_held; m_rr = n_rr;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_be = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_req = 0; m1_we = 0; m1_be = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
        s_gnt = 0; s_rvalid = 0; s_rdata = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        for (int c = 0; c < 3; c++) begin
            m0_req = 1'($urandom_range(0, 1)); m1_req = 1'($urandom_range(0, 1));
            m0_addr = $urandom; m1_addr = $urandom; m0_we = 1; m1_we = 1;
            s_gnt = 1; s_rvalid = 1; s_rdata = $urandom;
            #1; model_eval();
            checks++;
            if (obs_vec !== '0) begin
                errors++; $display("FAIL reset c%0d obs=%h exp=0", c, obs_vec);
            end
            adv();
        end
        rst_n = 1;
        idle_inputs();
    endtask

    task automatic test_single_read();
        for (int c = 0; c < 42; c++) begin
            idle_inputs();
            if (c == 0) begin
                m0_req = 1; m0_be = 4'hF; m0_addr = 32'h0000_0100; s_gnt = 1;
            end
            if (c == 40) begin
                s_rvalid = 1; s_rdata = 32'hDEAD_BEEF;
            end
            #1; model_eval();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL single_model c%0d obs=%h exp=%h", c, obs_vec, exp_vec);
            end
            if (c == 0) begin
                checks++;
                if ({m0_gnt, m1_gnt, s_addr} !== {2'b10, 32'h0000_0100}) begin
                    errors++; $display("FAIL single_gnt got=%b%b addr=%h want=10 00000100", m0_gnt, m1_gnt, s_addr);
                end
            end
            if (c == 40) begin
                checks++;
                if ({m0_rvalid, m1_rvalid, m0_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
                    errors++; $display("FAIL single_rsp got=%b%b data=%h want=10 deadbeef", m0_rvalid, m1_rvalid, m0_rdata);
                end
            end
            adv();
        end
    endtask

    task automatic test_contention();
        int  pend, wcnt, last, got, want;
        bit  done;
        exp_q = {32'd0, 32'd1, 32'd0, 32'd1};
        idle_inputs();
        rst_n = 0; #1; model_eval(); adv(); rst_n = 1;
        pend = 0; wcnt = 0; last = 0; done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            m0_req = exp_q.size() > 0; m1_req = exp_q.size() > 0;
            m0_we = 0; m1_we = 0; m0_be = 4'hF; m1_be = 4'h3;
            m0_addr = 32'h1000 + c; m1_addr = 32'h2000 + c;
            m0_wdata = $urandom; m1_wdata = $urandom;
            s_gnt = 1; s_rvalid = (pend != 0) && (wcnt == 3); s_rdata = $urandom;
            #1; model_eval();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL cont_model c%0d obs=%h exp=%h", c, obs_vec, exp_vec);
            end
            if (s_rvalid) begin
                checks++;
                if ({m1_rvalid, m0_rvalid} !== ((last == 1) ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL cont_owner rv=%b%b owner=%0d", m1_rvalid, m0_rvalid, last);
                end
                pend = 0;
            end
            if (m0_gnt || m1_gnt) begin
                got = m1_gnt ? 1 : 0;
                want = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : -1;
                checks++;
                if (got != want || (m0_gnt && m1_gnt) || pend != 0) begin
                    errors++; $display("FAIL cont_order got=%0d want=%0d pend=%0d", got, want, pend);
                end
                last = got; pend = 1; wcnt = 0;
            end
            adv();
            if (pend != 0) wcnt++;
            done = (exp_q.size() == 0) && (pend == 0);
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL cont_timeout left=%0d pend=%0d", exp_q.size(), pend);
        end
        idle_inputs();
    endtask

    task automatic test_held_selection();
        for (int c = 0; c < 12; c++) begin
            idle_inputs();
            m0_addr = 32'h0000_1000; m1_addr = 32'h0000_2000; m0_be = 4'hF; m1_be = 4'hF;
            m1_req = (c <= 5);
            m0_req = (c >= 1 && c <= 8);
            s_gnt = (c == 5 || c == 8);
            s_rvalid = (c == 7 || c == 10);
            s_rdata = $urandom;
            #1; model_eval();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL held_model c%0d obs=%h exp=%h", c, obs_vec, exp_vec);
            end
            if (c <= 5) begin
                checks++;
                if ({s_req, s_addr} !== {1'b1, 32'h0000_2000}) begin
                    errors++; $display("FAIL held_addr c%0d got=%b %h want=1 00002000", c, s_req, s_addr);
                end
            end
            if (c == 5) begin
                checks++;
                if ({m0_gnt, m1_gnt} !== 2'b01) begin
                    errors++; $display("FAIL held_gnt got=%b%b want=01", m0_gnt, m1_gnt);
                end
            end
            if (c == 8) begin
                checks++;
                if ({m0_gnt, m1_gnt} !== 2'b10) begin
                    errors++; $display("FAIL held_next got=%b%b want=10", m0_gnt, m1_gnt);
                end
            end
            adv();
        end
    endtask

    task automatic test_write();
        for (int c = 0; c < 3; c++) begin
            idle_inputs();
            if (c == 0) begin
                m1_req = 1; m1_we = 1; m1_be = 4'hF; m1_addr = 32'h00C0_0000; m1_wdata = 32'h1;
                s_gnt = 1;
            end
            if (c == 1) begin
                s_rvalid = 1; s_rdata = $urandom;
            end
            #1; model_eval();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL write_model c%0d obs=%h exp=%h", c, obs_vec, exp_vec);
            end
            if (c == 0) begin
                checks++;
                if ({s_we, s_addr, s_wdata, m1_gnt} !== {1'b1, 32'h00C0_0000, 32'h1, 1'b1}) begin
                    errors++; $display("FAIL write_fwd we=%b addr=%h data=%h gnt=%b", s_we, s_addr, s_wdata, m1_gnt);
                end
            end
            if (c == 1) begin
                checks++;
                if ({m0_rvalid, m1_rvalid} !== 2'b01) begin
                    errors++; $display("FAIL write_rsp got=%b%b want=01", m0_rvalid, m1_rvalid);
                end
            end
            adv();
        end
    endtask

    task automatic test_spurious_and_reset();
        for (int c = 0; c < 9; c++) begin
            idle_inputs();
            rst_n = (c != 3);
            m0_addr = 32'h0000_0400; m1_addr = 32'h0000_0800; m0_be = 4'hF; m1_be = 4'hF;
            s_rdata = $urandom;
            case (c)
                0: s_rvalid = 1;
                1: begin m0_req = 1; s_gnt = 1; end
                4: s_rvalid = 1;
                5: begin m0_req = 1; m1_req = 1; s_gnt = 1; end
                7: s_rvalid = 1;
                default: ;
            endcase
            #1; model_eval();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL spur_model c%0d obs=%h exp=%h", c, obs_vec, exp_vec);
            end
            if (c == 0 || c == 4) begin
                checks++;
                if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
                    errors++; $display("FAIL spur_rvalid c%0d got=%b%b want=00", c, m0_rvalid, m1_rvalid);
                end
            end
            if (c == 3) begin
                checks++;
                if (obs_vec !== '0) begin
                    errors++; $display("FAIL spur_reset obs=%h exp=0", obs_vec);
                end
            end
            if (c == 5) begin
                checks++;
                if ({m0_gnt, m1_gnt} !== 2'b10) begin
                    errors++; $display("FAIL spur_prio got=%b%b want=10", m0_gnt, m1_gnt);
                end
            end
            adv();
        end
        rst_n = 1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            m0_req = ($urandom_range(0, 99) < 55); m1_req = ($urandom_range(0, 99) < 55);
            m0_we = 1'($urandom_range(0, 1)); m1_we = 1'($urandom_range(0, 1));
            m0_be = 4'($urandom); m1_be = 4'($urandom);
            m0_addr = $urandom; m1_addr = $urandom; m0_wdata = $urandom; m1_wdata = $urandom;
            s_gnt = ($urandom_range(0, 99) < 50); s_rvalid = ($urandom_range(0, 99) < 30);
            s_rdata = $urandom;
            #1; model_eval();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL random c%0d obs=%h exp=%h", c, obs_vec, exp_vec);
            end
            adv();
        end
        rst_n = 1;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_held_selection();
        test_write();
        test_spurious_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
